mantissa_align: RTL and testbench

Alignment stage of the floating-point adder, placed directly downstream of the exponent-difference ALU. It takes the two IEEE-754 single-precision operands and the 9-bit exponent-difference word from that stage. It selects the larger-exponent operand and right-shifts the smaller operand's mantissa by the difference, STEP bits per cycle, with guard/round/sticky capture. It hands the aligned pair to the mantissa adder over a valid/ready handshake.

---
 rtl/mantissa_align.sv | 132 +++++++++++++
 tb/tb_mantissa_align.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mantissa_align.sv
// mantissa_align
// Alignment stage of the floating-point adder. Picks the operand with the
// larger exponent (selected by diff[8] from the upstream exponent-difference
// ALU) and right-shifts the other operand's {hidden, fraction} by diff[7:0],
// at most STEP bits per cycle, collecting guard/round/sticky bits.
//
// Ports:
//   clk, res        clock, asynchronous active-high reset
//   a, b            IEEE-754 single operands
//   diff            [7:0] |exp_a - exp_b|, [8] set when exp_b > exp_a
//   in_valid/ready  input handshake (ready only in IDLE)
//   out_valid/ready output handshake (valid only in DONE)
//   exp_out         larger exponent
//   mant_big        {hidden, fraction} of the larger operand
//   mant_small      aligned {hidden, fraction, G, R, S} of the smaller operand
//   sign_big/small  signs of the larger / other operand
//   swapped         B was chosen as the larger operand
//   state_dbg       current FSM state
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, stays high with stable data until accepted.
module mantissa_align #(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        res,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [8:0]  diff,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  exp_out,
  output logic [23:0] mant_big,
  output logic [26:0] mant_small,
  output logic        sign_big,
  output logic        sign_small,
  output logic        swapped,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [7:0] STEP_W = 8'(STEP);

  logic [1:0]  state;
  logic [7:0]  cnt;

  logic [31:0] big_op;
  logic [31:0] small_op;
  logic [23:0] small_mant;
  logic [7:0]  s;
  logic [26:0] out_mask;
  logic [26:0] shifted;
  logic        sticky;
  logic [26:0] v_next;

  always_comb begin
    big_op     = diff[8] ? b : a;
    small_op   = diff[8] ? a : b;
    // Hidden bit is 0 for zero/denormal exponents.
    small_mant = {|small_op[30:23], small_op[22:0]};
  end

  // One shift step: move by min(STEP, cnt); every bit that falls off the
  // bottom (old sticky included) is ORed back into the sticky position.
  always_comb begin
    s        = (cnt < STEP_W) ? cnt : STEP_W;
    out_mask = (27'd1 << s) - 27'd1;
    sticky   = |(mant_small & out_mask);
    shifted  = mant_small >> s;
    v_next   = {shifted[26:1], shifted[0] | sticky};
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state      <= IDLE;
      cnt        <= 8'd0;
      exp_out    <= 8'd0;
      mant_big   <= 24'd0;
      mant_small <= 27'd0;
      sign_big   <= 1'b0;
      sign_small <= 1'b0;
      swapped    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            exp_out    <= big_op[30:23];
            mant_big   <= {|big_op[30:23], big_op[22:0]};
            sign_big   <= big_op[31];
            sign_small <= small_op[31];
            swapped    <= diff[8];
            if (diff[7:0] == 8'd0) begin
              mant_small <= {small_mant, 3'b000};
              cnt        <= 8'd0;
              state      <= DONE;
            end else if (diff[7:0] >= 8'd27) begin
              // Everything lands below S; only "anything nonzero" survives.
              mant_small <= {26'd0, |small_mant};
              cnt        <= 8'd0;
              state      <= DONE;
            end else begin
              mant_small <= {small_mant, 3'b000};
              cnt        <= diff[7:0];
              state      <= SHIFT;
            end
          end
        end
        SHIFT: begin
          mant_small <= v_next;
          cnt        <= cnt - s;
          if (cnt == s) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == IDLE) && !res;
    out_valid = (state == DONE);
    state_dbg = state;
  end

endmodule

// File: tb/tb_mantissa_align.sv
module tb_mantissa_align;

  logic        clk;
  logic        res;
  logic [31:0] a;
  logic [31:0] b;
  logic [8:0]  diff;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  exp_out;
  logic [23:0] mant_big;
  logic [26:0] mant_small;
  logic        sign_big;
  logic        sign_small;
  logic        swapped;
  logic [1:0]  state_dbg;

  int checks;
  int failures;
  logic [26:0] exp_q[$];

  mantissa_align #(.STEP(4)) dut (
    .clk(clk), .res(res), .a(a), .b(b), .diff(diff),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .exp_out(exp_out), .mant_big(mant_big), .mant_small(mant_small),
    .sign_big(sign_big), .sign_small(sign_small), .swapped(swapped),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [8:0]  diff;
    logic [7:0]  exp_e;
    logic [23:0] mb_e;
    logic [26:0] ms_e;
    logic        sb_e;
    logic        ss_e;
    logic        sw_e;
    int          lat_e;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Present one operation, wait for capture, then count cycles to out_valid.
  // Latency 1 means out_valid is seen right after the capture edge.
  task automatic issue(input logic [31:0] av, input logic [31:0] bv,
                       input logic [8:0] dv, output int lat);
    int waitc;
    @(negedge clk);
    a = av; b = bv; diff = dv; in_valid = 1'b1;
    waitc = 0;
    while (!in_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    chk("in_ready_before_capture", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_after_accept_in_ready", {31'd0, in_ready}, 32'd1);
    chk("idle_after_accept_out_valid", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_exp_out"}, {24'd0, exp_out}, 32'd0);
    chk({tag, "_mant_big"}, {8'd0, mant_big}, 32'd0);
    chk({tag, "_mant_small"}, {5'd0, mant_small}, 32'd0);
    chk({tag, "_signs_swapped"}, {29'd0, sign_big, sign_small, swapped}, 32'd0);
  endtask

  initial begin
    int lat;
    logic [26:0] exp_ms;
    checks = 0;
    failures = 0;

    //         a             b             diff    exp    mant_big   mant_small  sb  ss  sw  lat
    vecs[0]  = '{32'h40400000, 32'h3F800000, 9'h001, 8'h80, 24'hC00000, 27'h2000000, 1'b0, 1'b0, 1'b0, 2};
    vecs[1]  = '{32'h3F800000, 32'hC0400000, 9'h101, 8'h80, 24'hC00000, 27'h2000000, 1'b1, 1'b0, 1'b1, 2};
    vecs[2]  = '{32'h4B000000, 32'h3F800001, 9'h017, 8'h96, 24'h800000, 27'h0000009, 1'b0, 1'b0, 1'b0, 7};
    vecs[3]  = '{32'h5F800000, 32'h3F800000, 9'h040, 8'hBF, 24'h800000, 27'h0000001, 1'b0, 1'b0, 1'b0, 1};
    vecs[4]  = '{32'h5F800000, 32'h00000000, 9'h040, 8'hBF, 24'h800000, 27'h0000000, 1'b0, 1'b0, 1'b0, 1};
    vecs[5]  = '{32'h3F800000, 32'hBFC00000, 9'h000, 8'h7F, 24'h800000, 27'h6000000, 1'b0, 1'b1, 1'b0, 1};
    vecs[6]  = '{32'h4C800000, 32'h3F800000, 9'h01A, 8'h99, 24'h800000, 27'h0000001, 1'b0, 1'b0, 1'b0, 8};
    vecs[7]  = '{32'h4D000000, 32'h3F800001, 9'h01B, 8'h9A, 24'h800000, 27'h0000001, 1'b0, 1'b0, 1'b0, 1};
    vecs[8]  = '{32'h43800000, 32'h3F800000, 9'h008, 8'h87, 24'h800000, 27'h0040000, 1'b0, 1'b0, 1'b0, 3};
    vecs[9]  = '{32'hC2000000, 32'h3F80000F, 9'h005, 8'h84, 24'h800000, 27'h0200003, 1'b1, 1'b0, 1'b0, 3};
    vecs[10] = '{32'h00800000, 32'h00000003, 9'h001, 8'h01, 24'h800000, 27'h000000C, 1'b0, 1'b0, 1'b0, 2};
    vecs[11] = '{32'h3F800000, 32'hBF800000, 9'h100, 8'h7F, 24'h800000, 27'h4000000, 1'b1, 1'b0, 1'b1, 1};
    vecs[12] = '{32'h41800000, 32'h3F800000, 9'h004, 8'h83, 24'h800000, 27'h0400000, 1'b0, 1'b0, 1'b0, 2};

    a = 32'd0; b = 32'd0; diff = 9'd0; in_valid = 1'b0; out_ready = 1'b0;
    res = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
    check_zero_outputs("reset");
    res = 1'b0;
    @(negedge clk);
    chk("post_reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Table-driven vectors.
    for (int i = 0; i < 13; i++) begin
      exp_q.push_back(vecs[i].ms_e);
      issue(vecs[i].a, vecs[i].b, vecs[i].diff, lat);
      exp_ms = exp_q.pop_front();
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat_e);
      chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_exp_out", i), {24'd0, exp_out}, {24'd0, vecs[i].exp_e});
      chk($sformatf("v%0d_mant_big", i), {8'd0, mant_big}, {8'd0, vecs[i].mb_e});
      chk($sformatf("v%0d_mant_small", i), {5'd0, mant_small}, {5'd0, exp_ms});
      chk($sformatf("v%0d_sign_big", i), {31'd0, sign_big}, {31'd0, vecs[i].sb_e});
      chk($sformatf("v%0d_sign_small", i), {31'd0, sign_small}, {31'd0, vecs[i].ss_e});
      chk($sformatf("v%0d_swapped", i), {31'd0, swapped}, {31'd0, vecs[i].sw_e});
      chk($sformatf("v%0d_in_ready_busy", i), {31'd0, in_ready}, 32'd0);
      accept();
    end

    // Backpressure: case 1 held in DONE while new data waits on in_valid.
    issue(32'h40400000, 32'h3F800000, 9'h001, lat);
    chk("bp_latency", lat, 2);
    a = 32'h5F800000; b = 32'h3F800000; diff = 9'h040; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("bp%0d_out_valid", k), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp%0d_in_ready", k), {31'd0, in_ready}, 32'd0);
      chk($sformatf("bp%0d_exp_out", k), {24'd0, exp_out}, 32'h80);
      chk($sformatf("bp%0d_mant_big", k), {8'd0, mant_big}, 32'hC00000);
      chk($sformatf("bp%0d_mant_small", k), {5'd0, mant_small}, 32'h2000000);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_new_out_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_new_exp_out", {24'd0, exp_out}, 32'hBF);
    chk("bp_new_mant_small", {5'd0, mant_small}, 32'h1);
    accept();

    // Reset during the third SHIFT cycle of case 3.
    @(negedge clk);
    a = 32'h4B000000; b = 32'h3F800001; diff = 9'h017; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mid_state_shift", {30'd0, state_dbg}, 32'd1);
    res = 1'b1;
    #1;
    chk("rst_mid_in_ready", {31'd0, in_ready}, 32'd0);
    check_zero_outputs("rst_mid");
    @(negedge clk);
    res = 1'b0;
    @(negedge clk);
    chk("rst_rel_in_ready", {31'd0, in_ready}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk($sformatf("rst_no_stale%0d", k), {31'd0, out_valid}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
